timer_period_meter: RTL and testbench
=====================================

Name: timer_period_meter

Overview:
- Measures the interval, in clk cycles, between two consecutive rising edges of a synchronous event input. Typical sources are the `done` ticks of the team's parameterised timers or any other periodic strobe.
- Acts as the receiving end of a tick generator: it counts cycles between ticks and reports the result with a one-cycle valid pulse.
- Supports single-shot and continuous measurement, abort, and saturation/overflow reporting.

Parameters:
- MAX_COUNT, default 1023: largest reportable period. Counter width CW = $clog2(MAX_COUNT+1) (localparam).
- CONTINUOUS, default 0:
  - 0: return to IDLE after each result.
  - 1: the closing edge also opens the next measurement.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  arm a measurement; sampled only in IDLE.
- abort  input  1  return to IDLE from any state; no result is produced.
- event_in  input  1  event line, synchronous to clk; edge-detected internally.
- busy  output  1  high in ARM or MEASURE.
- period  output  CW  last measured period; holds until the next result.
- valid  output  1  one-cycle pulse when period/overflow update.
- overflow  output  1  qualifies the current period value; 1 = interval exceeded MAX_COUNT.

Behaviour:
- Edge detect:
  - ev_d <= event_in every cycle, including in IDLE; ev_d resets to 0.
  - rise = event_in & ~ev_d.
  - A level held high produces exactly one rise.
- Synchronous reset (reset_n=0 at a clk edge): state=IDLE, cnt=0, ev_d=0, period=0, valid=0, overflow=0, busy=0. Takes precedence over all other inputs. Reset mid-measurement discards the partial count.
- States: IDLE, ARM, MEASURE. busy is combinational from state, so it is high in the same cycle the state is ARM/MEASURE.
- IDLE:
  - start=1 -> ARM next cycle.
  - Rises seen in IDLE are ignored.
- ARM:
  - Waits for rise. On rise -> MEASURE with cnt <= 1.
  - A rise in the same cycle start is sampled in IDLE does not count.
- MEASURE, evaluated in this priority order:
  1. abort -> IDLE; no valid.
  2. rise -> period <= cnt, overflow <= 0, valid <= 1 (visible the cycle after the rise).
     - CONTINUOUS=0: -> IDLE.
     - CONTINUOUS=1: stay in MEASURE, cnt <= 1.
  3. No rise and cnt == MAX_COUNT -> period <= MAX_COUNT, overflow <= 1, valid <= 1, -> IDLE regardless of CONTINUOUS.
  4. Otherwise cnt <= cnt + 1.
- Result definition: rises at cycles t0 and t1 give period = t1 - t0. The minimum reportable value is 1 (rises on back-to-back cycles need event_in to toggle, so the practical minimum is 2).
- Rise coinciding with cnt == MAX_COUNT is a normal result: period=MAX_COUNT, overflow=0.
- abort:
  - Effective in ARM and MEASURE; ignored in IDLE.
  - abort beats start in IDLE: start with abort high does not arm.
  - period and overflow are not changed by abort.
- start while busy is ignored; it does not restart the count.
- valid is a registered output, high for exactly one cycle per result and 0 otherwise.
- cnt never exceeds MAX_COUNT; no wrap-around.
- Outputs period, overflow and valid are registers.

Test Plan:
1. Single shot:
   - Stimulus: reset, start pulse, then event_in rising at cycle 10 and cycle 15 (high 1 cycle each).
   - Response: valid one cycle after cycle 15, period=5, overflow=0, busy low afterwards.
   - A further rise at cycle 20 produces no valid.
2. Continuous (CONTINUOUS=1):
   - Stimulus: rises at 10, 13, 20, 28.
   - Response: three valid pulses with period=3, 7, 8 in order; busy stays high.
   - Then abort: busy drops next cycle, no extra valid, period stays 8.
3. Overflow (MAX_COUNT=15):
   - Stimulus: start, first rise, no further edge.
   - Response: valid with period=15, overflow=1 exactly 15 cycles after the first rise; state IDLE.
   - Boundary: second rise at exactly +15 gives period=15, overflow=0.
4. Level and ignore rules:
   - event_in held high for 50 cycles after arming yields one rise only, so no result.
   - A second start pulse mid-MEASURE does not alter the result (period=6 for rises 6 cycles apart).
   - Rises in IDLE produce nothing.
5. Reset mid-operation:
   - Stimulus: reset_n low for 1 cycle during MEASURE at cnt=4.
   - Response: next cycle busy=0, period=0, valid=0, overflow=0.
   - A following rise without start produces no valid.
6. Priority:
   - abort and rise in the same MEASURE cycle -> no valid, IDLE.
   - start and abort together in IDLE -> stays IDLE.

Source files
------------

// File: rtl/timer_period_meter.sv
// timer_period_meter
// Counts clk cycles between two consecutive rising edges of event_in and
// reports the interval with a one-cycle valid pulse. Supports single-shot or
// continuous operation, abort, and saturation at MAX_COUNT (overflow).
//
// Handshake: valid is a registered one-cycle strobe; period/overflow are
// registered and hold their value until the next valid. There is no ready:
// the consumer must capture period/overflow on the cycle valid is high
// (they stay stable afterwards until the next result anyway).

module timer_period_meter #(
  parameter int MAX_COUNT  = 1023,
  parameter bit CONTINUOUS = 1'b0,
  localparam int CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic          event_in,
  output logic          busy,
  output logic [CW-1:0] period,
  output logic          valid,
  output logic          overflow,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          ev_q;
  logic [CW-1:0] period_q;
  logic          valid_q;
  logic          overflow_q;
  logic          rise;

  // A held-high level gives exactly one rise because ev_q follows event_in.
  assign rise = event_in & ~ev_q;

  // Edge-detect register plus measurement FSM with registered results.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ev_q       <= 1'b0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ev_q    <= event_in;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // abort beats start; rises are ignored while idle
          if (start && !abort) state_q <= ARM;
        end
        ARM: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (rise) begin
            state_q <= MEASURE;
            cnt_q   <= ONE_C;
          end
        end
        MEASURE: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (rise) begin
            period_q   <= cnt_q;
            overflow_q <= 1'b0;
            valid_q    <= 1'b1;
            if (CONTINUOUS) cnt_q <= ONE_C;
            else            state_q <= IDLE;
          end else if (cnt_q == MAX_C) begin
            // saturate: report MAX_COUNT flagged as overflow, never wrap
            period_q   <= MAX_C;
            overflow_q <= 1'b1;
            valid_q    <= 1'b1;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + ONE_C;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign period    = period_q;
  assign valid     = valid_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_timer_period_meter.sv
// Bench for timer_period_meter: one single-shot and one continuous instance
// (both MAX_COUNT=15) share the same stimulus and are compared every cycle
// against an interval-based reference model, plus literal expectations.

module tb_timer_period_meter;

  localparam int MAXC = 15;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic event_in = 1'b0;

  logic       d0_busy, d0_valid, d0_ovf;
  logic [3:0] d0_period;
  logic [1:0] d0_state;
  logic       d1_busy, d1_valid, d1_ovf;
  logic [3:0] d1_period;
  logic [1:0] d1_state;

  timer_period_meter #(.MAX_COUNT(MAXC), .CONTINUOUS(1'b0)) u_single (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .event_in(event_in), .busy(d0_busy), .period(d0_period),
    .valid(d0_valid), .overflow(d0_ovf), .dbg_state(d0_state)
  );

  timer_period_meter #(.MAX_COUNT(MAXC), .CONTINUOUS(1'b1)) u_cont (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .event_in(event_in), .busy(d1_busy), .period(d1_period),
    .valid(d1_valid), .overflow(d1_ovf), .dbg_state(d1_state)
  );

  int checks = 0;
  int errors = 0;

  // reference model: mode 0 idle, 1 waiting for first rise, 2 measuring
  // since the rise at cycle m_t0; period is simply the elapsed cycle count
  int cyc = 0;
  bit m_prev_ev = 1'b0;
  int m_mode[2];
  int m_t0[2];
  int m_period[2];
  bit m_ovf[2];
  bit m_valid[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_update(input bit s, input bit a, input bit e, input bit r);
    bit rise;
    cyc++;
    if (!r) begin
      m_prev_ev = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0; m_t0[i] = 0; m_period[i] = 0; m_ovf[i] = 0; m_valid[i] = 0;
      end
      return;
    end
    rise = e && !m_prev_ev;
    m_prev_ev = e;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      if (m_mode[i] == 0) begin
        if (s && !a) m_mode[i] = 1;
      end else if (m_mode[i] == 1) begin
        if (a) m_mode[i] = 0;
        else if (rise) begin m_mode[i] = 2; m_t0[i] = cyc; end
      end else begin
        if (a) m_mode[i] = 0;
        else if (rise) begin
          m_period[i] = cyc - m_t0[i]; m_ovf[i] = 0; m_valid[i] = 1;
          if (i == 1) m_t0[i] = cyc; else m_mode[i] = 0;
        end else if (cyc - m_t0[i] == MAXC) begin
          m_period[i] = MAXC; m_ovf[i] = 1; m_valid[i] = 1; m_mode[i] = 0;
        end
      end
    end
  endtask

  // scoreboard compare, run once per cycle shortly after the active edge
  task automatic compare_all();
    chk("s_busy",   d0_busy,   m_mode[0] != 0);
    chk("s_valid",  d0_valid,  m_valid[0]);
    chk("s_period", d0_period, m_period[0]);
    chk("s_ovf",    d0_ovf,    m_ovf[0]);
    chk("c_busy",   d1_busy,   m_mode[1] != 0);
    chk("c_valid",  d1_valid,  m_valid[1]);
    chk("c_period", d1_period, m_period[1]);
    chk("c_ovf",    d1_ovf,    m_ovf[1]);
  endtask

  // driver: apply inputs, let one edge happen, update model, compare
  task automatic step(input bit s, input bit a, input bit e, input bit r);
    start = s; abort = a; event_in = e; reset_n = r;
    @(posedge clk);
    model_update(s, a, e, r);
    #1;
    compare_all();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1);
  endtask

  // n-1 low cycles then one high cycle: rise exactly n cycles after the last
  task automatic gap_rise(input int n);
    idle_n(n - 1);
    step(0, 0, 1, 1);
  endtask

  task automatic settle();
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
  endtask

  int nonovf;
  int density;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_t0[i] = 0; m_period[i] = 0; m_ovf[i] = 0; m_valid[i] = 0;
    end

    // reset state
    step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    chk("rst_busy", d0_busy, 0);
    chk("rst_period", d0_period, 0);
    chk("rst_valid", d0_valid, 0);
    chk("rst_ovf", d1_ovf, 0);
    idle_n(2);

    // single shot: period 5, then a further rise gives nothing
    step(1, 0, 0, 1);
    idle_n(3);
    step(0, 0, 1, 1);
    gap_rise(5);
    chk("ss_valid", d0_valid, 1);
    chk("ss_period", d0_period, 5);
    chk("ss_ovf", d0_ovf, 0);
    chk("ss_busy_after", d0_busy, 0);
    chk("ss_cont_busy", d1_busy, 1);
    gap_rise(5);
    chk("ss_no_more", d0_valid, 0);
    chk("ss_cont_valid", d1_valid, 1);
    step(0, 1, 0, 1);
    chk("ss_abort_busy", d1_busy, 0);
    chk("ss_abort_period", d1_period, 5);
    step(0, 0, 0, 1);

    // continuous: 3, 7, 8, then abort
    step(1, 0, 0, 1);
    idle_n(2);
    step(0, 0, 1, 1);
    gap_rise(3);
    chk("ct_p3", d1_period, 3);
    gap_rise(7);
    chk("ct_p7", d1_period, 7);
    gap_rise(8);
    chk("ct_p8", d1_period, 8);
    chk("ct_busy", d1_busy, 1);
    step(0, 1, 0, 1);
    chk("ct_abort_busy", d1_busy, 0);
    chk("ct_abort_valid", d1_valid, 0);
    chk("ct_abort_period", d1_period, 8);
    step(0, 0, 0, 1);

    // overflow exactly 15 cycles after the first rise
    step(1, 0, 0, 1);
    step(0, 0, 1, 1);
    idle_n(14);
    chk("ov_not_yet", d0_valid, 0);
    step(0, 0, 0, 1);
    chk("ov_valid", d0_valid, 1);
    chk("ov_period", d0_period, 15);
    chk("ov_flag", d0_ovf, 1);
    chk("ov_cont_idle", d1_busy, 0);
    settle();

    // boundary: rise at exactly +15 is a normal result
    step(1, 0, 0, 1);
    step(0, 0, 1, 1);
    gap_rise(15);
    chk("bd_valid", d0_valid, 1);
    chk("bd_period", d0_period, 15);
    chk("bd_ovf", d0_ovf, 0);
    settle();

    // held level: a single rise, so no non-overflow result
    step(1, 0, 0, 1);
    nonovf = 0;
    for (int i = 0; i < 50; i++) begin
      step(0, 0, 1, 1);
      if (d0_valid && !d0_ovf) nonovf++;
      if (d1_valid && !d1_ovf) nonovf++;
    end
    chk("lvl_one_rise", nonovf, 0);
    settle();

    // start while measuring is ignored
    step(1, 0, 0, 1);
    step(0, 0, 1, 1);
    idle_n(2);
    step(1, 0, 0, 1);
    gap_rise(3);
    chk("ms_period", d0_period, 6);
    chk("ms_cont_period", d1_period, 6);
    settle();

    // rises in idle produce nothing
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1);
      chk("idle_valid", d0_valid, 0);
      step(0, 0, 0, 1);
    end

    // reset mid-measure at cnt=4
    step(1, 0, 0, 1);
    step(0, 0, 1, 1);
    idle_n(3);
    step(0, 0, 0, 0);
    chk("mr_busy", d0_busy, 0);
    chk("mr_period", d0_period, 0);
    chk("mr_valid", d0_valid, 0);
    chk("mr_ovf", d0_ovf, 0);
    step(0, 0, 1, 1);
    chk("mr_no_result", d0_valid, 0);
    step(0, 0, 0, 1);

    // abort and rise together, then start and abort together in idle
    step(1, 0, 0, 1);
    step(0, 0, 1, 1);
    idle_n(2);
    step(0, 1, 1, 1);
    chk("pr_valid", d0_valid, 0);
    chk("pr_busy", d0_busy, 0);
    step(1, 1, 0, 1);
    chk("pr_start_abort", d0_busy, 0);
    step(0, 0, 0, 1);

    // randomized traffic with varying event density
    density = 1;
    for (int i = 0; i < 3000; i++) begin
      bit s, a, e, r;
      if (i % 64 == 0) density = $urandom_range(0, 3) == 0 ? 1 :
                                  ($urandom_range(0, 1) ? 4 : 20);
      s = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 40) == 0);
      r = ($urandom_range(0, 400) != 0);
      e = ($urandom_range(0, density) == 0) ? ~event_in : event_in;
      step(s, a, e, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
